// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial front end, the byte queue and the serializer.
package deserializer_pkg;

  // Default word width. The queue data width must match it.
  localparam int WORD_W = 8;

  // Deserializer control states.
  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    OFFER    = 2'd1,
    WAIT_ACK = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel front end. Assembles WIDTH bits MSB first, offers the word
// to the queue with a one-cycle enqueue strobe, then waits for a consumer ack.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             queue_full_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready_out,
  output logic             status_out
);

  // The count must be able to hold WIDTH itself, so it gets one extra bit.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_t     state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             bit_take;
  logic             word_done;

  assign shifted    = {shift_reg[WIDTH-2:0], data_in};
  assign bit_take   = (state == COLLECT) && write_in;
  assign word_done  = bit_take && (count == LAST);
  assign status_out = (state == COLLECT);

  // Next-state logic: collect -> offer (held off by backpressure) -> wait for ack.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT:  if (word_done)      state_nxt = OFFER;
      OFFER:    if (!queue_full_in) state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_in)         state_nxt = COLLECT;
      default:                      state_nxt = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Datapath: shift bits in, publish the finished word, and pulse the enqueue
  // strobe on the single edge that leaves OFFER.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      shift_reg      <= '0;
      data_out       <= '0;
      data_ready_out <= 1'b0;
    end else begin
      data_ready_out <= 1'b0;
      if (word_done) begin
        data_out  <= shifted;
        shift_reg <= '0;
        count     <= '0;
      end else if (bit_take) begin
        shift_reg <= shifted;
        count     <= count + 1'b1;
      end
      if (state == OFFER && !queue_full_in) data_ready_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: stimulus pushes expected words into a
// scoreboard queue; a monitor pops and compares on every enqueue strobe.
module tb_deserializer;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       queue_full_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       data_ready_out;
  logic       status_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_ready = 1'b0;

  deserializer #(.WIDTH(8)) dut (
    .clk_10KHz      (clk),
    .reset          (reset),
    .data_in        (data_in),
    .write_in       (write_in),
    .queue_full_in  (queue_full_in),
    .ack_in         (ack_in),
    .data_out       (data_out),
    .data_ready_out (data_ready_out),
    .status_out     (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    write_in = 1'b1;
    data_in  = b;
    step();
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap_mod);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap_mod > 0 && i > 0)
        for (int g = 0; g < (i % gap_mod); g++) step();
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected word and
  // last exactly one cycle.
  always @(negedge clk) begin
    if (reset && data_ready_out) begin
      if (prev_ready) begin
        checks++;
        errors++;
        $display("FAIL pulse_width: strobe high on consecutive cycles");
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: data_out %0h with no word expected", data_out);
      end else begin
        check("sb_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_ready = data_ready_out;
  end

  initial begin
    reset = 1'b0; data_in = 1'b0; write_in = 1'b0;
    queue_full_in = 1'b0; ack_in = 1'b0;
    step(); step();
    check("rst_data_out", {24'd0, data_out}, 32'h0);
    check("rst_ready",    {31'd0, data_ready_out}, 32'd0);
    check("rst_status",   {31'd0, status_out}, 32'd1);
    reset = 1'b1;
    step();

    // Back-to-back bits of A5; strobe one edge after the 8th bit.
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 0);
    check("a5_status_offer", {31'd0, status_out}, 32'd0);
    check("a5_ready_n",      {31'd0, data_ready_out}, 32'd0);
    step();
    check("a5_ready_n1", {31'd0, data_ready_out}, 32'd1);
    check("a5_data",     {24'd0, data_out}, 32'hA5);
    step();
    check("a5_ready_n2",  {31'd0, data_ready_out}, 32'd0);
    check("a5_status_wa", {31'd0, status_out}, 32'd0);
    step();
    check("a5_status_noack", {31'd0, status_out}, 32'd0);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    check("a5_status_ack", {31'd0, status_out}, 32'd1);

    // Same word held off by a full queue for 5 cycles.
    exp_q.push_back(8'hA5);
    queue_full_in = 1'b1;
    send_word(8'hA5, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_ready", {31'd0, data_ready_out}, 32'd0);
      check("full_hold",  {24'd0, data_out}, 32'hA5);
    end
    queue_full_in = 1'b0;
    step();
    check("full_release_ready", {31'd0, data_ready_out}, 32'd1);
    step();
    check("full_release_fall", {31'd0, data_ready_out}, 32'd0);
    ack_in = 1'b1; step(); ack_in = 1'b0;

    // 3C with 0-3 idle cycles between strobes.
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 4);
    check("gap_status", {31'd0, status_out}, 32'd0);
    // Stray bits in OFFER (held by backpressure) and in WAIT_ACK are dropped.
    queue_full_in = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(i[0]);
    queue_full_in = 1'b0;
    step();
    check("gap_ready", {31'd0, data_ready_out}, 32'd1);
    for (int i = 0; i < 3; i++) send_bit(~i[0]);
    check("stray_hold", {24'd0, data_out}, 32'h3C);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 0);
    step(); step();
    ack_in = 1'b1; step(); ack_in = 1'b0;
    check("ff_data", {24'd0, data_out}, 32'hFF);

    // Reset mid-word discards partial bits.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_data",   {24'd0, data_out}, 32'h0);
    check("mid_rst_ready",  {31'd0, data_ready_out}, 32'd0);
    check("mid_rst_status", {31'd0, status_out}, 32'd1);
    step();
    reset = 1'b1;
    exp_q.push_back(8'h01);
    send_word(8'h01, 0);
    step();
    check("post_rst_data", {24'd0, data_out}, 32'h01);
    step();
    ack_in = 1'b1; step(); ack_in = 1'b0;

    // ack in COLLECT and OFFER has no effect; ack at edge N+2 is accepted.
    ack_in = 1'b1; step(); step(); ack_in = 1'b0;
    check("ack_collect_status", {31'd0, status_out}, 32'd1);
    exp_q.push_back(8'h5A);
    queue_full_in = 1'b1;
    send_word(8'h5A, 0);
    ack_in = 1'b1; step(); step(); ack_in = 1'b0;
    check("ack_offer_status", {31'd0, status_out}, 32'd0);
    check("ack_offer_ready",  {31'd0, data_ready_out}, 32'd0);
    queue_full_in = 1'b0;
    step();
    check("late_ready", {31'd0, data_ready_out}, 32'd1);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    check("ack_n2_status", {31'd0, status_out}, 32'd1);
    check("ack_n2_ready",  {31'd0, data_ready_out}, 32'd0);
    check("data_5a",       {24'd0, data_out}, 32'h5A);

    step(); step();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Serial-to-parallel front end that sits directly upstream of the byte queue (fila).
- Collects one bit per write_in strobe and assembles WIDTH-bit words, MSB first.
- Offers each completed word to the queue with a single-cycle enqueue pulse and honours queue backpressure.
- Waits for a consumer acknowledge before accepting the next word's bits.

Parameters:
- WIDTH, 8, word width in bits; must equal the queue's data width.

Ports:
- clk_10KHz  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- data_in  input  1  serial data bit; sampled only when write_in=1 in COLLECT.
- write_in  input  1  bit-valid strobe; one bit is consumed per cycle it is high in COLLECT.
- queue_full_in  input  1  backpressure from the downstream queue; 1 = enqueue not allowed.
- ack_in  input  1  acknowledge that the offered word has been taken; releases the block for a new word.
- data_out  output  WIDTH  assembled word; drives the queue's data_in.
- data_ready_out  output  1  enqueue strobe to the queue; high for exactly one cycle per word.
- status_out  output  1  1 = ready to accept serial bits (state COLLECT).

Behaviour:
- Reset (reset=0, asynchronous, overrides everything):
  - state=COLLECT, bit count=0, shift register=0.
  - data_out=0, data_ready_out=0, status_out=1.
- States: COLLECT, OFFER, WAIT_ACK (2-bit encoding).
- status_out is combinational: 1 iff state==COLLECT. data_out and data_ready_out are registered.
- COLLECT:
  - On an edge with write_in=1: shift_reg <= {shift_reg[WIDTH-2:0], data_in}; count++. The first bit received ends up as data_out[WIDTH-1].
  - On the edge that captures bit number WIDTH: data_out <= final assembled word, count <= 0, state -> OFFER.
  - write_in=0: hold all state; gaps between bits of any length are legal.
- OFFER:
  - write_in and ack_in are ignored; bits arriving here are dropped.
  - queue_full_in=1: stay in OFFER, data_ready_out=0, data_out held.
  - queue_full_in=0 at an edge: data_ready_out <= 1, state -> WAIT_ACK.
- WAIT_ACK:
  - data_ready_out <= 0 on the first edge in this state, giving exactly one high cycle.
  - Stay until ack_in=1 is sampled, then state -> COLLECT.
  - data_out is held through WAIT_ACK and through later COLLECT cycles until the next word completes.
  - write_in is ignored in this state.
- Latency (bit WIDTH captured at edge N, queue not full):
  - state OFFER after N.
  - data_ready_out high between edges N+1 and N+2.
  - Earliest return to COLLECT is at edge N+2, if ack_in=1 there.
- Simultaneous events:
  - ack_in=1 at edge N+2 is accepted; data_ready_out still falls at that edge.
  - ack_in outside WAIT_ACK has no effect.
- Reset mid-word discards any partial bits; the next word starts from bit 0.
- count width is $clog2(WIDTH)+1 so a count of WIDTH is representable; no wrap-around within a word.

Decomposition:
- Shared package: state enum typedef (COLLECT/OFFER/WAIT_ACK) and the default word-width constant (8), reused by the queue and the downstream serializer.
- No sub-module: one FSM, one shift register and one counter in a single module.

Test Plan:
- Reset, then bits 1,0,1,0,0,1,0,1 on consecutive write_in cycles -> data_out=8'hA5; data_ready_out high for exactly 1 cycle, one cycle after the 8th bit; status_out=0 until ack_in.
- Same word with queue_full_in=1 held for 5 cycles after the 8th bit -> data_ready_out stays 0 and data_out=8'hA5 is held; pulse occurs on the first edge after queue_full_in falls.
- Bits of 8'h3C delivered with 0-3 idle cycles between write_in strobes -> data_out=8'h3C with the same single pulse.
- Toggle write_in and data_in during OFFER/WAIT_ACK, then ack_in=1, then send 8'hFF -> stray bits dropped; next word is exactly 8'hFF.
- After 3 bits (1,1,1), drive reset=0 for 1 cycle, then send 8'h01 -> data_out=8'h01 with no leftover bits; all outputs at reset values during reset.
- ack_in pulsed in COLLECT and OFFER -> no state change; ack_in sampled at edge N+2 -> status_out=1 from that edge.
